// File: rtl/imu_spi_seq_pkg.sv
// Shared state encoding and SPI command words for the IMU sequencer.
// Combinational definitions only; no latency or flow control of its own.
package imu_spi_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_CFG0  = 3'd1,
        ST_CFG1  = 3'd2,
        ST_CFG2  = 3'd3,
        ST_IDLE  = 3'd4,
        ST_RDL   = 3'd5,
        ST_RDH   = 3'd6
    } state_t;

    localparam logic [15:0] CMD_CFG0    = 16'h0D02;
    localparam logic [15:0] CMD_CFG1    = 16'h1160;
    localparam logic [15:0] CMD_CFG2    = 16'h1440;
    localparam logic [15:0] CMD_RD_YAWL = 16'hA600;
    localparam logic [15:0] CMD_RD_YAWH = 16'hA700;

endpackage

// File: rtl/imu_spi_seq_if.sv
// SPI monarch handshake plus yaw-sample output; master = sequencer side.
// Pure wiring, no latency; the monarch throttles via done, the sample sink cannot stall.
interface imu_spi_seq_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rspns;
    logic [15:0] yaw_rt;
    logic        vld;

    modport master (output wrt, output cmd, output yaw_rt, output vld,
                    input  done, input rspns);
    modport slave  (input  wrt, input  cmd, input  yaw_rt, input  vld,
                    output done, output rspns);
endinterface

// File: rtl/imu_spi_seq_sync2.sv
// Two-flop synchronizer for an asynchronous level, resets to 0.
// Latency 2 clocks; no flow control.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/imu_spi_seq.sv
// Power-up wait, three config writes, then a low/high yaw-rate read per data-ready.
// Each step waits indefinitely for a rising done from the monarch; INT is 3 clocks to wrt.
module imu_spi_seq
    import imu_spi_pkg::*;
#(
    parameter int PWRUP_BITS = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_int,
    imu_spi_seq_if.master  bus
);
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PWRUP_BITS-1:0]   r_cnt;
    logic                    r_done_q;
    logic [7:0]              r_lo;
    logic                    r_wrt;
    logic [15:0]             r_cmd;
    logic [15:0]             r_yaw;
    logic                    r_vld;
    logic                    w_int_s;
    logic                    w_done_rise;
    logic                    w_load;
    logic [15:0]             w_cmd_nxt;
    logic                    w_lo_ld;
    logic                    w_yaw_ld;

    sync2 u_int_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_int),
        .o_q     (w_int_s)
    );

    // Only an edge counts: done is left high between transactions.
    assign w_done_rise = bus.done & ~r_done_q;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cmd_nxt   = r_cmd;
        w_lo_ld     = 1'b0;
        w_yaw_ld    = 1'b0;
        case (r_state)
            ST_PWRUP: if (&r_cnt) begin
                w_state_nxt = ST_CFG0;
                w_load      = 1'b1;
                w_cmd_nxt   = CMD_CFG0;
            end
            ST_CFG0: if (w_done_rise) begin
                w_state_nxt = ST_CFG1;
                w_load      = 1'b1;
                w_cmd_nxt   = CMD_CFG1;
            end
            ST_CFG1: if (w_done_rise) begin
                w_state_nxt = ST_CFG2;
                w_load      = 1'b1;
                w_cmd_nxt   = CMD_CFG2;
            end
            ST_CFG2: if (w_done_rise) begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: if (w_int_s) begin
                w_state_nxt = ST_RDL;
                w_load      = 1'b1;
                w_cmd_nxt   = CMD_RD_YAWL;
            end
            ST_RDL: if (w_done_rise) begin
                w_state_nxt = ST_RDH;
                w_load      = 1'b1;
                w_cmd_nxt   = CMD_RD_YAWH;
                w_lo_ld     = 1'b1;
            end
            ST_RDH: if (w_done_rise) begin
                w_state_nxt = ST_IDLE;
                w_yaw_ld    = 1'b1;
            end
            default: w_state_nxt = ST_PWRUP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_PWRUP;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 r_cnt <= '0;
        else if (r_state == ST_PWRUP) r_cnt <= r_cnt + PWRUP_BITS'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_q <= 1'b0;
            r_lo     <= 8'h00;
        end else begin
            r_done_q <= bus.done;
            if (w_lo_ld) r_lo <= bus.rspns[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrt <= 1'b0;
            r_cmd <= 16'h0000;
            r_yaw <= 16'h0000;
            r_vld <= 1'b0;
        end else begin
            r_wrt <= w_load;
            r_cmd <= w_cmd_nxt;
            r_vld <= w_yaw_ld;
            if (w_yaw_ld) r_yaw <= {bus.rspns[7:0], r_lo};
        end
    end

    assign bus.wrt    = r_wrt;
    assign bus.cmd    = r_cmd;
    assign bus.yaw_rt = r_yaw;
    assign bus.vld    = r_vld;
endmodule

// File: tb/tb_imu_spi_seq.sv
// Drives imu_spi_seq with a behavioural SPI monarch and random latencies/responses.
module tb_imu_spi_seq;
    logic clk;
    logic rst_n;
    logic int_in;
    int   n_cmp;
    int   n_err;
    int   n_wrt;

    logic [15:0] cfg_q [3];

    imu_spi_seq_if bus ();

    imu_spi_seq #(.PWRUP_BITS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_int   (int_in),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.wrt === 1'b1) n_wrt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Waits for the next wrt pulse; latency counted in negedges from the call.
    task automatic expect_wrt(input string tag, input int lat, input logic [15:0] c);
        int n;
        n = -1;
        for (int k = 1; k <= lat + 20; k++) begin
            @(negedge clk);
            if (bus.wrt === 1'b1) begin
                n = k;
                break;
            end
        end
        chk({tag, "_lat"}, n, lat);
        if (n > 0) chk({tag, "_cmd"}, bus.cmd, c);
    endtask

    // Monarch model: accept the command, then answer after lat clocks.
    task automatic complete(input int lat, input logic [15:0] resp);
        @(negedge clk);
        bus.done = 1'b0;
        chk("wrt_drop", bus.wrt, 1'b0);
        repeat (lat) @(negedge clk);
        bus.rspns = resp;
        bus.done  = 1'b1;
    endtask

    task automatic quiet(input string tag, input int cycles);
        int c;
        #1 c = n_wrt;
        repeat (cycles) @(negedge clk);
        #1 chk(tag, n_wrt, c);
    endtask

    task automatic run_cfg(input string tag);
        expect_wrt({tag, "_pwrup"}, 16, cfg_q[0]);
        for (int i = 0; i < 3; i++) begin
            complete($urandom_range(1, 4), 16'($urandom));
            if (i < 2) expect_wrt({tag, "_cfg"}, 1, cfg_q[i+1]);
        end
        quiet({tag, "_idle_quiet"}, 12);
    endtask

    // Entered at the negedge where the RDL wrt was seen.
    task automatic read_body(input bit hold, input bit pulse);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'($urandom) | 16'h0001;
        hi = 16'($urandom);
        if (!hold) int_in = 1'b0;
        if (pulse) begin
            @(negedge clk) int_in = 1'b1;
            @(negedge clk) int_in = 1'b0;
        end
        complete($urandom_range(1, 5), lo);
        expect_wrt("rdh", 1, 16'hA700);
        complete($urandom_range(1, 5), hi);
        @(negedge clk);
        chk("vld_hi", bus.vld, 1'b1);
        chk("yaw", bus.yaw_rt, {hi[7:0], lo[7:0]});
        @(negedge clk);
        chk("vld_lo", bus.vld, 1'b0);
        chk("yaw_hold", bus.yaw_rt, {hi[7:0], lo[7:0]});
        if (hold) begin
            chk("reread_wrt", bus.wrt, 1'b1);
            chk("reread_cmd", bus.cmd, 16'hA600);
        end
    endtask

    task automatic do_read(input bit pulse);
        int_in = 1'b1;
        expect_wrt("rdl", 3, 16'hA600);
        read_body(1'b0, pulse);
        quiet("post_read_quiet", 8);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_wrt = 0;
        cfg_q[0] = 16'h0D02;
        cfg_q[1] = 16'h1160;
        cfg_q[2] = 16'h1440;
        rst_n     = 1'b0;
        int_in    = 1'b0;
        bus.done  = 1'b0;
        bus.rspns = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_wrt", bus.wrt, 1'b0);
        chk("rst_cmd", bus.cmd, 16'h0000);
        chk("rst_yaw", bus.yaw_rt, 16'h0000);
        chk("rst_vld", bus.vld, 1'b0);
        rst_n = 1'b1;
        run_cfg("boot");

        for (int i = 0; i < 4; i++) do_read(i[0]);

        int_in = 1'b1;
        expect_wrt("held_rdl", 3, 16'hA600);
        int_in = 1'b0;
        quiet("held_done_no_adv", 10);
        chk("held_done_cmd", bus.cmd, 16'hA600);
        read_body(1'b0, 1'b0);

        int_in = 1'b1;
        expect_wrt("hold_rdl", 3, 16'hA600);
        read_body(1'b1, 1'b0);
        read_body(1'b0, 1'b0);
        quiet("hold_end_quiet", 8);

        int_in = 1'b1;
        expect_wrt("rst_rdl", 3, 16'hA600);
        int_in = 1'b0;
        complete(2, 16'h00CD);
        expect_wrt("rst_rdh", 1, 16'hA700);
        rst_n    = 1'b0;
        bus.done = 1'b0;
        #1;
        chk("midrst_wrt", bus.wrt, 1'b0);
        chk("midrst_vld", bus.vld, 1'b0);
        chk("midrst_yaw", bus.yaw_rt, 16'h0000);
        chk("midrst_cmd", bus.cmd, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cfg("reboot");
        do_read(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
